// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the 32-entry register file.
package regfile_pkg;

  localparam int NUM_REGS         = 32;
  localparam int ADDR_W           = 5;
  localparam int DATA_W_DEFAULT   = 64;
  localparam int ZERO_REG_DEFAULT = 31;

  // Binary address to one-hot select, qualified by an enable.
  // A disabled write yields an all-zero vector, so nothing downstream
  // can load no matter what the address lines carry.
  function automatic logic [NUM_REGS-1:0] decode_onehot(
    input logic              en,
    input logic [ADDR_W-1:0] addr
  );
    logic [NUM_REGS-1:0] sel;
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && (addr == ADDR_W'(i))) begin
        sel[i] = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_reg_en.sv
// Single DATA_W-bit storage register with load enable and synchronous clear.
module reg_en #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Clear wins over load, so a write that coincides with reset is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile.sv
// 32 x DATA_W register file: one write port, two combinational read ports.
// The register at ZERO_REG has no storage and always reads as zero.
// Reads never see the data being written in the same cycle; the new value
// appears only after the clock edge that stores it.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int ZERO_REG = ZERO_REG_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  logic [NUM_REGS-1:0] wsel;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  // One-hot write select; all zero whenever RegWrite is low.
  always_comb begin
    wsel = decode_onehot(RegWrite, WriteRegister);
  end

  // Storage: one enabled register per index, the zero index is a constant.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i == ZERO_REG) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_store
      reg_en #(
        .DATA_W (DATA_W)
      ) u_reg (
        .clk   (clk),
        .reset (reset),
        .en    (wsel[i]),
        .d     (WriteData),
        .q     (regs[i])
      );
    end
  end

  // Read port 1: 32:1 mux, zero latency.
  always_comb begin
    ReadData1 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ReadRegister1 == ADDR_W'(i)) begin
        ReadData1 = regs[i];
      end
    end
  end

  // Read port 2: independent 32:1 mux, zero latency.
  always_comb begin
    ReadData2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ReadRegister2 == ADDR_W'(i)) begin
        ReadData2 = regs[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: driver tasks queue expected read data,
// a negedge monitor pops and compares against both read ports.
module tb_regfile;

  localparam int W = 64;

  logic         clk;
  logic         reset;
  logic         RegWrite;
  logic [4:0]   WriteRegister;
  logic [W-1:0] WriteData;
  logic [4:0]   ReadRegister1;
  logic [4:0]   ReadRegister2;
  logic [W-1:0] ReadData1;
  logic [W-1:0] ReadData2;

  // Read request strobe: the monitor compares while it is high.
  logic         chk_v;

  logic [W-1:0] exp1_q[$];
  logic [W-1:0] exp2_q[$];
  string        name_q[$];

  logic [W-1:0] model [32];

  int n_checks;
  int n_pass;

  regfile #(
    .DATA_W   (64),
    .ZERO_REG (31)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit (got running, need finished)");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [W-1:0] d);
    RegWrite      = 1'b1;
    WriteRegister = a;
    WriteData     = d;
    @(posedge clk); #1;
    RegWrite      = 1'b0;
    if (a != 5'd31) model[a] = d;
  endtask

  // Presents both read addresses for one cycle and queues expectations.
  // Any write set up before the call lands on the edge that ends it.
  task automatic rd(input logic [4:0] a1, input logic [4:0] a2,
                    input logic [W-1:0] e1, input logic [W-1:0] e2,
                    input string nm);
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    exp1_q.push_back(e1);
    exp2_q.push_back(e2);
    name_q.push_back(nm);
    chk_v = 1'b1;
    @(posedge clk); #1;
    chk_v = 1'b0;
  endtask

  task automatic sweep_model(input string nm);
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i), model[i], model[31 - i], nm);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (chk_v) begin
      logic [W-1:0] e1, e2;
      string nm;
      n_checks += 2;
      if (exp1_q.size() == 0 || exp2_q.size() == 0 || name_q.size() == 0) begin
        $display("FAIL scoreboard_underflow: got empty queue, need pending entry");
      end else begin
        e1 = exp1_q.pop_front();
        e2 = exp2_q.pop_front();
        nm = name_q.pop_front();
        if (ReadData1 === e1) n_pass++;
        else $display("FAIL %s rd1[%0d]: got %h need %h", nm, ReadRegister1, ReadData1, e1);
        if (ReadData2 === e2) n_pass++;
        else $display("FAIL %s rd2[%0d]: got %h need %h", nm, ReadRegister2, ReadData2, e2);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks      = 0;
    n_pass        = 0;
    chk_v         = 1'b0;
    reset         = 1'b1;
    RegWrite      = 1'b0;
    WriteRegister = '0;
    WriteData     = '0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Power-up reset pulse, then every address reads zero on both ports.
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 32; i++) rd(5'(i), 5'(i), '0, '0, "reset_zero");

    // Fill all registers with distinct values (index 31 discarded).
    for (int i = 0; i < 32; i++) wr(5'(i), {8{8'(i + 1)}} ^ 64'hA5A5_0000_5A5A_0000);
    sweep_model("fill");

    // Reset mid-sequence wipes everything.
    do_reset();
    sweep_model("midreset");

    // RegWrite low for 3 cycles with a toggling address/data: reg 7 untouched.
    for (int i = 0; i < 3; i++) begin
      WriteRegister = (i == 1) ? 5'd8 : 5'd7;
      WriteData     = (i == 1) ? 64'h5555 : 64'hAAAA;
      @(posedge clk); #1;
    end
    rd(5'd7, 5'd8, 64'h0, 64'h0, "nowrite");

    // Write then read on independent ports.
    wr(5'd5,  64'h0123_4567_89AB_CDEF);
    wr(5'd30, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(5'd5, 5'd30, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, "wr_rd");
    rd(5'd30, 5'd30, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "same_addr");

    // Zero register ignores writes; nothing else moves.
    wr(5'd31, 64'hDEAD_BEEF);
    rd(5'd31, 5'd31, 64'h0, 64'h0, "zero_reg");
    sweep_model("zero_reg_others");

    // Read during write: old value before the edge, new one after.
    wr(5'd3, 64'h11);
    RegWrite      = 1'b1;
    WriteRegister = 5'd3;
    WriteData     = 64'h22;
    rd(5'd3, 5'd5, 64'h11, 64'h0123_4567_89AB_CDEF, "rdw_before");
    RegWrite      = 1'b0;
    model[3]      = 64'h22;
    rd(5'd3, 5'd3, 64'h22, 64'h22, "rdw_after");

    // Reset beats a simultaneous write.
    wr(5'd10, 64'h77);
    rd(5'd10, 5'd3, 64'h77, 64'h22, "pre_rst_wr");
    reset         = 1'b1;
    RegWrite      = 1'b1;
    WriteRegister = 5'd10;
    WriteData     = 64'h55;
    @(posedge clk); #1;
    reset         = 1'b0;
    RegWrite      = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    rd(5'd10, 5'd5, 64'h0, 64'h0, "rst_vs_wr");
    sweep_model("rst_vs_wr_all");

    // Every queued expectation must have been consumed.
    @(negedge clk);
    n_checks++;
    if (exp1_q.size() == 0 && exp2_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending, need 0", exp1_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
